// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file with busy-bit scoreboard.
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int NWR_DEF   = 2;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;
endpackage

// File: rtl/regfile_sb_if.sv
// Read, writeback and issue signals between decode/issue, writeback and the register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF,
  parameter int NWR   = NWR_DEF,
  localparam int AW   = $clog2(NREGS)
);
  logic [NRD-1:0][AW-1:0]   rs_addr;
  logic [NRD-1:0][XLEN-1:0] rs_data;
  logic [NRD-1:0]           rs_ready;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     iss_valid;
  logic [AW-1:0]            iss_rd;
  logic                     iss_ready;
  logic                     flush;

  modport slave (
    input  rs_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, flush,
    output rs_data, rs_ready, iss_ready
  );

  modport master (
    output rs_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, flush,
    input  rs_data, rs_ready, iss_ready
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue reserves rd, writeback releases it, flush clears all.
// A same-cycle reserve beats a release; flush beats both. Register 0 is never busy.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF,
  parameter int NWR   = NWR_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_rd,
  output logic                   iss_ready,
  input  logic                   flush,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR-1:0][AW-1:0] wr_addr,
  input  logic [NRD-1:0][AW-1:0] rs_addr,
  output logic [NRD-1:0]         rs_busy
);
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] wr_hit;
  logic             iss_set;

  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) wr_hit[wr_addr[w]] = 1'b1;
    end

    // A writeback landing this cycle frees rd for an immediate re-reservation.
    iss_ready = (iss_rd == '0) || !busy_q[iss_rd] || wr_hit[iss_rd];
    iss_set   = iss_valid && iss_ready && (iss_rd != '0);

    busy_d = busy_q & ~wr_hit;
    if (iss_set) busy_d[iss_rd] = 1'b1;
    if (flush)   busy_d = '0;
    busy_d[0] = 1'b0;

    for (int r = 0; r < NRD; r++) begin
      rs_busy[r] = busy_q[rs_addr[r]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end
endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with scoreboard; x0 is hardwired zero.
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF,
  parameter int NWR   = NWR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0][XLEN-1:0] regs_d;
  logic [NRD-1:0]             rs_busy;

  rf_scoreboard #(.NREGS(NREGS), .NRD(NRD), .NWR(NWR)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .iss_ready (bus.iss_ready),
    .flush     (bus.flush),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .rs_addr   (bus.rs_addr),
    .rs_busy   (rs_busy)
  );

  // Ascending port order so the highest-index writer of a shared target wins.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NWR; w++) begin
      if (bus.wr_en[w] && (bus.wr_addr[w] != '0)) regs_d[bus.wr_addr[w]] = bus.wr_data[w];
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs_q <= '0;
    else      regs_q <= regs_d;
  end

  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      bus.rs_data[r]  = regs_q[bus.rs_addr[r]];
      bus.rs_ready[r] = !rs_busy[r];
`ifdef RF_BYPASS_EN
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] && (bus.wr_addr[w] == bus.rs_addr[r]) && (bus.wr_addr[w] != '0)) begin
          bus.rs_data[r]  = bus.wr_data[w];
          bus.rs_ready[r] = 1'b1;
        end
      end
`else
`endif
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default build or RF_BYPASS_EN).
module tb_regfile_sb;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en     = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic test_reset();
    bus.rs_addr = '0;
    idle();
    #3;
    n_vec++;
    if (bus.rs_ready !== 2'b11) begin n_err++; $display("FAIL reset_rs_ready got=%b exp=11", bus.rs_ready); end
    n_vec++;
    if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL reset_iss_ready got=%b exp=1", bus.iss_ready); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 5'd5; bus.wr_data[0] = 32'hDEADBEEF;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    tick();
    idle();
    bus.rs_addr[0] = 5'd5;
    #1;
    n_vec++;
    if (bus.rs_data[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL pre_reset_x5 got=%h exp=deadbeef", bus.rs_data[0]); end
    n_vec++;
    if (bus.rs_ready[0] !== 1'b0) begin n_err++; $display("FAIL pre_reset_busy5 got=%b exp=0", bus.rs_ready[0]); end
    #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.rs_data[0] !== 32'h0) begin n_err++; $display("FAIL async_reset_x5 got=%h exp=0", bus.rs_data[0]); end
    @(negedge clk);
    rst = 1'b1;
    bus.iss_rd = 5'd5;
    #1;
    n_vec++;
    if (bus.rs_ready[0] !== 1'b1) begin n_err++; $display("FAIL reset_busy5_clear got=%b exp=1", bus.rs_ready[0]); end
    n_vec++;
    if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL reset_iss5 got=%b exp=1", bus.iss_ready); end
    tick();
  endtask

  task automatic test_x0();
    idle();
    bus.wr_en = 2'b11; bus.wr_addr[0] = 5'd0; bus.wr_data[0] = 32'h1234;
    bus.wr_addr[1] = 5'd0; bus.wr_data[1] = 32'h5678;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    bus.rs_addr[0] = 5'd0; bus.rs_addr[1] = 5'd0;
    #1;
    n_vec++;
    if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL x0_iss_ready got=%b exp=1", bus.iss_ready); end
    n_vec++;
    if (bus.rs_data[0] !== 32'h0) begin n_err++; $display("FAIL x0_bypass_data got=%h exp=0", bus.rs_data[0]); end
    tick();
    idle();
    #1;
    n_vec++;
    if (bus.rs_data !== 64'h0) begin n_err++; $display("FAIL x0_read got=%h exp=0", bus.rs_data); end
    n_vec++;
    if (bus.rs_ready !== 2'b11) begin n_err++; $display("FAIL x0_ready got=%b exp=11", bus.rs_ready); end
    n_vec++;
    if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL x0_not_busy got=%b exp=1", bus.iss_ready); end
  endtask

  task automatic test_hazard();
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    #1;
    n_vec++;
    if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL haz_first_issue got=%b exp=1", bus.iss_ready); end
    tick();
    bus.rs_addr[0] = 5'd7; bus.rs_addr[1] = 5'd7;
    #1;
    n_vec++;
    if (bus.rs_ready !== 2'b00) begin n_err++; $display("FAIL haz_raw got=%b exp=00", bus.rs_ready); end
    n_vec++;
    if (bus.iss_ready !== 1'b0) begin n_err++; $display("FAIL haz_waw got=%b exp=0", bus.iss_ready); end
    tick();
    n_vec++;
    if (bus.iss_ready !== 1'b0) begin n_err++; $display("FAIL haz_waw_hold got=%b exp=0", bus.iss_ready); end
    bus.iss_valid = 1'b0;
    bus.wr_en[1] = 1'b1; bus.wr_addr[1] = 5'd7; bus.wr_data[1] = 32'hA5A5A5A5;
    #1;
    n_vec++;
    if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL haz_wb_iss_ready got=%b exp=1", bus.iss_ready); end
    tick();
    idle();
    bus.iss_rd = 5'd7;
    #1;
    n_vec++;
    if (bus.rs_ready !== 2'b11) begin n_err++; $display("FAIL haz_wb_ready got=%b exp=11", bus.rs_ready); end
    n_vec++;
    if (bus.rs_data[1] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL haz_wb_data got=%h exp=a5a5a5a5", bus.rs_data[1]); end
    n_vec++;
    if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL haz_released got=%b exp=1", bus.iss_ready); end
  endtask

  task automatic test_conflict();
    idle();
    bus.wr_en = 2'b11;
    bus.wr_addr[0] = 5'd3; bus.wr_data[0] = 32'h11;
    bus.wr_addr[1] = 5'd3; bus.wr_data[1] = 32'h22;
    tick();
    bus.wr_addr[0] = 5'd10; bus.wr_data[0] = 32'h1010;
    bus.wr_addr[1] = 5'd11; bus.wr_data[1] = 32'h1111;
    tick();
    idle();
    bus.rs_addr[0] = 5'd3; bus.rs_addr[1] = 5'd10;
    #1;
    n_vec++;
    if (bus.rs_data[0] !== 32'h22) begin n_err++; $display("FAIL conflict_x3 got=%h exp=22", bus.rs_data[0]); end
    n_vec++;
    if (bus.rs_ready !== 2'b11) begin n_err++; $display("FAIL conflict_ready got=%b exp=11", bus.rs_ready); end
    n_vec++;
    if (bus.rs_data[1] !== 32'h1010) begin n_err++; $display("FAIL dual_x10 got=%h exp=1010", bus.rs_data[1]); end
    bus.rs_addr[1] = 5'd11;
    #1;
    n_vec++;
    if (bus.rs_data[1] !== 32'h1111) begin n_err++; $display("FAIL dual_x11 got=%h exp=1111", bus.rs_data[1]); end
  endtask

  task automatic test_set_clear();
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    tick();
    bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 5'd9; bus.wr_data[0] = 32'h99;
    #1;
    n_vec++;
    if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL setclr_iss_ready got=%b exp=1", bus.iss_ready); end
    tick();
    idle();
    bus.rs_addr[0] = 5'd9;
    #1;
    n_vec++;
    if (bus.rs_ready[0] !== 1'b0) begin n_err++; $display("FAIL set_wins got=%b exp=0", bus.rs_ready[0]); end
    n_vec++;
    if (bus.rs_data[0] !== 32'h99) begin n_err++; $display("FAIL setclr_data got=%h exp=99", bus.rs_data[0]); end
    bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 5'd9; bus.wr_data[0] = 32'h9A;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9; bus.flush = 1'b1;
    tick();
    idle();
    bus.iss_rd = 5'd9;
    #1;
    n_vec++;
    if (bus.rs_ready[0] !== 1'b1) begin n_err++; $display("FAIL flush_wins got=%b exp=1", bus.rs_ready[0]); end
    n_vec++;
    if (bus.rs_data[0] !== 32'h9A) begin n_err++; $display("FAIL flush_write_data got=%h exp=9a", bus.rs_data[0]); end
    n_vec++;
    if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL flush_iss_ready got=%b exp=1", bus.iss_ready); end
  endtask

  task automatic test_flush_only();
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd12;
    tick();
    idle();
    bus.flush = 1'b1;
    bus.rs_addr[1] = 5'd12;
    #1;
    n_vec++;
    if (bus.rs_ready[1] !== 1'b0) begin n_err++; $display("FAIL flush_pre_busy got=%b exp=0", bus.rs_ready[1]); end
    tick();
    idle();
    #1;
    n_vec++;
    if (bus.rs_ready[1] !== 1'b1) begin n_err++; $display("FAIL flush_clears got=%b exp=1", bus.rs_ready[1]); end
  endtask

  task automatic test_bypass();
    idle();
    bus.rs_addr[0] = 5'd4;
    bus.wr_en[1] = 1'b1; bus.wr_addr[1] = 5'd4; bus.wr_data[1] = 32'hCAFE;
    #1;
`ifdef RF_BYPASS_EN
    n_vec++;
    if (bus.rs_data[0] !== 32'hCAFE) begin n_err++; $display("FAIL bypass_same_cycle got=%h exp=cafe", bus.rs_data[0]); end
`else
    n_vec++;
    if (bus.rs_data[0] !== 32'h0) begin n_err++; $display("FAIL nobypass_old got=%h exp=0", bus.rs_data[0]); end
`endif
    n_vec++;
    if (bus.rs_ready[0] !== 1'b1) begin n_err++; $display("FAIL bypass_ready got=%b exp=1", bus.rs_ready[0]); end
    tick();
    idle();
    #1;
    n_vec++;
    if (bus.rs_data[0] !== 32'hCAFE) begin n_err++; $display("FAIL bypass_next got=%h exp=cafe", bus.rs_data[0]); end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_hazard();
    test_conflict();
    test_set_clear();
    test_flush_only();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
